// File: rtl/oam_dma.sv
// Sprite DMA: copies CPU page $XX00-$XXFF into PPU OAM while holding the CPU
// halted. Outputs are registered except oam_addr, which tracks oam_base live.
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_wr,
  input  logic        odd_or_even,
  input  logic [7:0]  oam_base,
  output logic        dma_hijack,
  output logic [15:0] dma_addr,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        dma_done,
  output logic [2:0]  state_dbg
);

  localparam logic [15:0] OAM_REG = 16'h4014;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_GET   = 3'd3,
    S_PUT   = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] dbuf;
  logic       last;

  assign state_dbg = state;
  assign oam_data  = dbuf;
  assign oam_addr  = oam_base + idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      dbuf       <= 8'h00;
      last       <= 1'b0;
      dma_hijack <= 1'b0;
      dma_addr   <= 16'h0000;
      oam_we     <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      oam_we   <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_addr == OAM_REG && !bus_wr) begin
            page       <= bus_din;
            idx        <= 8'h00;
            last       <= 1'b0;
            dma_hijack <= 1'b1;
            state      <= S_HALT;
          end
        end
        S_HALT: begin
          // An odd HALT needs one extra dummy cycle so GET lands on an even cycle.
          if (odd_or_even) begin
            state <= S_ALIGN;
          end else begin
            dma_addr <= {page, idx};
            state    <= S_GET;
          end
        end
        S_ALIGN: begin
          dma_addr <= {page, idx};
          state    <= S_GET;
        end
        S_GET: begin
          dbuf     <= bus_din;
          last     <= (idx == 8'hFF);
          oam_we   <= 1'b1;
          dma_done <= (idx == 8'hFF);
          state    <= S_PUT;
        end
        S_PUT: begin
          if (last) begin
            dma_hijack <= 1'b0;
            state      <= S_IDLE;
          end else begin
            // The index wraps inside the page; the page never increments.
            idx      <= idx + 8'd1;
            dma_addr <= {page, idx + 8'd1};
            state    <= S_GET;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: table of transfers plus hand sequences for
// reset mid-transfer and non-triggering accesses.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic [7:0]  cpu_din;
  logic        bus_wr;
  logic        odd_or_even = 1'b0;
  logic [7:0]  oam_base;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        dma_done;
  logic [2:0]  state_dbg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GET  = 3'd3;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_din    (bus_din),
    .bus_wr     (bus_wr),
    .odd_or_even(odd_or_even),
    .oam_base   (oam_base),
    .dma_hijack (dma_hijack),
    .dma_addr   (dma_addr),
    .oam_we     (oam_we),
    .oam_addr   (oam_addr),
    .oam_data   (oam_data),
    .dma_done   (dma_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset / cycle parity
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 odd_or_even = ~odd_or_even;
  end

  // Source memory: page $02 holds i^$5A, other pages are offset by page.
  function automatic logic [7:0] src(input logic [15:0] a);
    return (a[7:0] ^ 8'h5A) + (a[15:8] - 8'h02);
  endfunction

  assign bus_din = dma_hijack ? src(dma_addr) : cpu_din;

  // OAM storage model, written on the strobe edge
  logic [7:0] oam_mem [256];
  logic       oam_clr = 1'b0;
  always @(posedge clk) begin
    if (oam_clr) begin
      for (int i = 0; i < 256; i++) oam_mem[i] <= 8'hEE;
    end else if (oam_we) begin
      oam_mem[oam_addr] <= oam_data;
    end
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] page;
    logic [7:0] base;
    logic       halt_odd;
    logic       immediate;
    logic       retrig;
  } vec_t;

  vec_t vecs [6];

  task automatic run_xfer(input vec_t v, input int id);
    int len = 0, we_cnt = 0, done_cnt = 0, first_we = -1, get_cnt = 0, addr_bad = 0;
    logic halt_odd;
    logic retrig_done = 1'b0, retrig_armed = 1'b0;
    logic [15:0] e;
    oam_base = v.base;
    if (v.immediate) begin
      halt_odd = ~odd_or_even;
    end else begin
      halt_odd = v.halt_odd;
      while (odd_or_even == halt_odd) @(negedge clk);
    end
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({v.base + i[7:0], src({v.page, i[7:0]})});
    end
    bus_addr = 16'h4014;
    bus_wr   = 1'b0;
    cpu_din  = v.page;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (k == 1 || retrig_armed) begin
        bus_addr     = 16'h0000;
        bus_wr       = 1'b1;
        retrig_armed = 1'b0;
      end
      if (v.retrig && !retrig_done && k >= 40 && state_dbg == ST_GET) begin
        bus_addr     = 16'h4014;
        bus_wr       = 1'b0;
        cpu_din      = 8'h77;
        retrig_done  = 1'b1;
        retrig_armed = 1'b1;
      end
      if (!dma_hijack) break;
      len++;
      if (state_dbg == ST_GET) begin
        if (dma_addr !== {v.page, get_cnt[7:0]}) addr_bad++;
        get_cnt++;
      end
      if (oam_we) begin
        we_cnt++;
        if (first_we < 0) first_we = k;
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_sb_underflow", id), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_byte%0d", id, we_cnt - 1), {16'h0, oam_addr, oam_data}, {16'h0, e});
        end
      end
      if (dma_done) begin
        done_cnt++;
        check($sformatf("v%0d_done_we_index", id), we_cnt, 256);
        check($sformatf("v%0d_done_with_we", id), {31'h0, oam_we}, 32'd1);
      end
    end
    check($sformatf("v%0d_hijack_len", id), len, halt_odd ? 514 : 513);
    check($sformatf("v%0d_we_count", id), we_cnt, 256);
    check($sformatf("v%0d_done_count", id), done_cnt, 1);
    check($sformatf("v%0d_first_we_cycle", id), first_we, halt_odd ? 4 : 3);
    check($sformatf("v%0d_get_count", id), get_cnt, 256);
    check($sformatf("v%0d_get_addr_bad", id), addr_bad, 0);
    check($sformatf("v%0d_sb_left", id), exp_q.size(), 0);
    exp_q.delete();
    bus_addr = 16'h0000;
    bus_wr   = 1'b1;
    if (dma_hijack) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    int seen, wcnt, filled;
    bus_addr = 16'h0000;
    bus_wr   = 1'b1;
    cpu_din  = 8'h00;
    oam_base = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_hijack", {31'h0, dma_hijack}, 32'd0);
    check("rst_oam_we", {31'h0, oam_we}, 32'd0);
    check("rst_done", {31'h0, dma_done}, 32'd0);
    check("rst_dma_addr", {16'h0, dma_addr}, 32'h0);
    check("rst_oam_addr", {24'h0, oam_addr}, 32'h0);
    check("rst_oam_data", {24'h0, oam_data}, 32'h0);
    check("rst_state", {29'h0, state_dbg}, {29'h0, ST_IDLE});
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{page: 8'h02, base: 8'h00, halt_odd: 1'b0, immediate: 1'b0, retrig: 1'b0};
    vecs[1] = '{page: 8'h02, base: 8'h00, halt_odd: 1'b1, immediate: 1'b0, retrig: 1'b0};
    vecs[2] = '{page: 8'h03, base: 8'hF0, halt_odd: 1'b0, immediate: 1'b0, retrig: 1'b0};
    vecs[3] = '{page: 8'hFF, base: 8'h00, halt_odd: 1'b1, immediate: 1'b0, retrig: 1'b0};
    vecs[4] = '{page: 8'h02, base: 8'h33, halt_odd: 1'b0, immediate: 1'b1, retrig: 1'b0};
    vecs[5] = '{page: 8'h81, base: 8'h10, halt_odd: 1'b1, immediate: 1'b0, retrig: 1'b1};

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i], i);
      if (i == 2) begin
        check("wrap_f0", {24'h0, oam_mem[8'hF0]}, {24'h0, src(16'h0300)});
        check("wrap_00", {24'h0, oam_mem[8'h00]}, {24'h0, src(16'h0310)});
        check("wrap_ef", {24'h0, oam_mem[8'hEF]}, {24'h0, src(16'h03FF)});
      end
      if (i == 3) check("pageff_addr_hold", {16'h0, dma_addr}, 32'hFFFF);
    end

    // reads of $4014 and writes elsewhere must not start a transfer
    seen = 0;
    repeat (2) @(negedge clk);
    bus_addr = 16'h4014; bus_wr = 1'b1; cpu_din = 8'h05;
    repeat (4) begin
      @(negedge clk);
      if (dma_hijack) seen++;
    end
    bus_addr = 16'h4015; bus_wr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dma_hijack) seen++;
    end
    bus_addr = 16'h0000; bus_wr = 1'b1;
    check("no_trigger_hijack", seen, 0);
    check("no_trigger_state", {29'h0, state_dbg}, {29'h0, ST_IDLE});

    // reset after the 100th OAM write
    oam_clr = 1'b1;
    @(negedge clk);
    oam_clr  = 1'b0;
    oam_base = 8'h00;
    bus_addr = 16'h4014; bus_wr = 1'b0; cpu_din = 8'h02;
    wcnt = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin bus_addr = 16'h0000; bus_wr = 1'b1; end
      if (oam_we) wcnt++;
      if (wcnt == 100) break;
    end
    check("rst_mid_we_seen", wcnt, 100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_hijack", {31'h0, dma_hijack}, 32'd0);
    check("rst_mid_we", {31'h0, oam_we}, 32'd0);
    check("rst_mid_addr", {16'h0, dma_addr}, 32'h0);
    check("rst_mid_data", {24'h0, oam_data}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    filled = 0;
    for (int i = 0; i < 256; i++) if (oam_mem[i] !== 8'hEE) filled++;
    check("rst_mid_bytes_written", filled, 100);
    check("rst_mid_byte99", {24'h0, oam_mem[8'd99]}, {24'h0, src(16'h0263)});
    check("rst_mid_byte100", {24'h0, oam_mem[8'd100]}, 32'hEE);
    run_xfer('{page: 8'h02, base: 8'h00, halt_odd: 1'b0, immediate: 1'b0, retrig: 1'b0}, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
